modbus_tx_frame_sched: RTL and testbench

Response-frame scheduler for the Modbus RTU slave. It starts when the function handler pulses `handler_done`. It then reads result words out of the response DPRAM, builds the full RTU response (slave address, function code, payload, CRC16) and streams it byte-by-byte to the UART transmitter over a valid/ready handshake. It owns the DPRAM read port and is the only sequencer of the transmit datapath.

---
 rtl/modbus_tx_frame_sched.sv | 196 +++++++++++++++++++
 tb/tb_modbus_tx_frame_sched.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/modbus_tx_frame_sched.sv
// Modbus RTU response-frame scheduler: builds address/function/payload/CRC16
// and streams the frame byte-by-byte to the UART over valid/ready.
module modbus_tx_frame_sched #(
    parameter int MAX_QTY  = 125,
    parameter int DPRAM_AW = 8
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic [7:0]          dev_addr,
    input  logic                handler_done,
    input  logic [7:0]          func_code,
    input  logic [15:0]         addr,
    input  logic [15:0]         data,
    input  logic [7:0]          tx_quantity,
    input  logic [7:0]          exception,
    output logic [DPRAM_AW-1:0] dpram_raddr,
    input  logic [15:0]         dpram_rdata,
    output logic                tx_byte_valid,
    output logic [7:0]          tx_byte,
    input  logic                tx_byte_ready,
    output logic                busy,
    output logic                frame_done,
    output logic                overrun
);
    typedef enum logic [3:0] {
        IDLE, HDR, BODY, RD_REQ, RD_WAIT, DATA_HI, DATA_LO, CRC_LO, CRC_HI, DONE
    } state_t;

    localparam logic [7:0] QTY_MAX = 8'(MAX_QTY);

    state_t              state_q;
    logic [7:0]          fc_q, exc_q, qty_q, idx_q, word_lo_q, byte_q;
    logic [15:0]         addr_q, data_q, crc_q;
    logic [1:0]          bidx_q;
    logic                valid_q, busy_q, done_q, ovr_q;
    logic [DPRAM_AW-1:0] raddr_q;

    logic        is_exc, is_rd, xfer, start_ok;
    logic [15:0] crc_nxt;
    logic [7:0]  qty_in, idx_inc, body_first, wr_next;

    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++)
            r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    assign is_exc   = exc_q != 8'h00;
    assign is_rd    = (fc_q == 8'h03) || (fc_q == 8'h04);
    assign xfer     = valid_q && tx_byte_ready;
    assign crc_nxt  = crc16_byte(crc_q, byte_q);
    assign qty_in   = (tx_quantity > QTY_MAX) ? QTY_MAX : tx_quantity;
    assign idx_inc  = idx_q + 8'd1;
    assign start_ok = (exception != 8'h00) || (func_code == 8'h03) ||
                      (func_code == 8'h04) || (func_code == 8'h06);

    // First body byte: exception code, read byte count, or write-echo address high
    assign body_first = is_exc ? exc_q : (is_rd ? {qty_q[6:0], 1'b0} : addr_q[15:8]);

    always_comb begin
        wr_next = 8'h00;
        case (bidx_q)
            2'd0:    wr_next = addr_q[7:0];
            2'd1:    wr_next = data_q[15:8];
            2'd2:    wr_next = data_q[7:0];
            default: wr_next = 8'h00;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            fc_q      <= 8'h00;
            exc_q     <= 8'h00;
            qty_q     <= 8'h00;
            idx_q     <= 8'h00;
            word_lo_q <= 8'h00;
            byte_q    <= 8'h00;
            addr_q    <= 16'h0000;
            data_q    <= 16'h0000;
            crc_q     <= 16'hFFFF;
            bidx_q    <= 2'd0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            ovr_q     <= 1'b0;
            raddr_q   <= '0;
        end else begin
            done_q <= 1'b0;
            ovr_q  <= handler_done && busy_q;
            // CRC covers every byte accepted ahead of the CRC itself
            if (xfer && (state_q == HDR || state_q == BODY || state_q == DATA_HI || state_q == DATA_LO))
                crc_q <= crc_nxt;
            case (state_q)
                IDLE: begin
                    crc_q <= 16'hFFFF;
                    if (handler_done) begin
                        fc_q    <= func_code;
                        exc_q   <= exception;
                        addr_q  <= addr;
                        data_q  <= data;
                        qty_q   <= qty_in;
                        idx_q   <= 8'h00;
                        bidx_q  <= 2'd0;
                        byte_q  <= dev_addr;
                        valid_q <= start_ok;
                        busy_q  <= 1'b1;
                        state_q <= HDR;
                    end
                end
                HDR: begin
                    if (!valid_q) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else if (xfer) begin
                        if (bidx_q == 2'd0) begin
                            bidx_q <= 2'd1;
                            byte_q <= is_exc ? (fc_q | 8'h80) : fc_q;
                        end else begin
                            bidx_q  <= 2'd0;
                            byte_q  <= body_first;
                            state_q <= BODY;
                        end
                    end
                end
                BODY: begin
                    if (xfer) begin
                        if (is_exc || (!is_rd && bidx_q == 2'd3) || (is_rd && qty_q == 8'h00)) begin
                            byte_q  <= crc_nxt[7:0];
                            state_q <= CRC_LO;
                        end else if (is_rd) begin
                            valid_q <= 1'b0;
                            raddr_q <= DPRAM_AW'(idx_q);
                            state_q <= RD_REQ;
                        end else begin
                            bidx_q <= bidx_q + 2'd1;
                            byte_q <= wr_next;
                        end
                    end
                end
                RD_REQ: state_q <= RD_WAIT;
                RD_WAIT: begin
                    word_lo_q <= dpram_rdata[7:0];
                    byte_q    <= dpram_rdata[15:8];
                    valid_q   <= 1'b1;
                    state_q   <= DATA_HI;
                end
                DATA_HI: begin
                    if (xfer) begin
                        byte_q  <= word_lo_q;
                        state_q <= DATA_LO;
                    end
                end
                DATA_LO: begin
                    if (xfer) begin
                        idx_q <= idx_inc;
                        if (idx_inc < qty_q) begin
                            valid_q <= 1'b0;
                            raddr_q <= DPRAM_AW'(idx_inc);
                            state_q <= RD_REQ;
                        end else begin
                            byte_q  <= crc_nxt[7:0];
                            state_q <= CRC_LO;
                        end
                    end
                end
                CRC_LO: begin
                    if (xfer) begin
                        byte_q  <= crc_q[15:8];
                        state_q <= CRC_HI;
                    end
                end
                CRC_HI: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE:    state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign dpram_raddr   = raddr_q;
    assign tx_byte_valid = valid_q;
    assign tx_byte       = byte_q;
    assign busy          = busy_q;
    assign frame_done    = done_q;
    assign overrun       = ovr_q;
endmodule

// File: tb/tb_modbus_tx_frame_sched.sv
// Bench for modbus_tx_frame_sched: byte-list frame model plus a per-cycle
// compare process, driven by directed frames.
module tb_modbus_tx_frame_sched;
    localparam int MAXQ = 125;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  dev_addr, func_code, tx_quantity, exception;
    logic        handler_done;
    logic [15:0] addr, data, dpram_rdata;
    logic [7:0]  dpram_raddr;
    logic        tx_byte_valid, tx_byte_ready, busy, frame_done, overrun;
    logic [7:0]  tx_byte;

    always #5 clk_in = ~clk_in;

    modbus_tx_frame_sched #(.MAX_QTY(MAXQ), .DPRAM_AW(8)) dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in), .dev_addr(dev_addr),
        .handler_done(handler_done), .func_code(func_code), .addr(addr),
        .data(data), .tx_quantity(tx_quantity), .exception(exception),
        .dpram_raddr(dpram_raddr), .dpram_rdata(dpram_rdata),
        .tx_byte_valid(tx_byte_valid), .tx_byte(tx_byte),
        .tx_byte_ready(tx_byte_ready), .busy(busy), .frame_done(frame_done),
        .overrun(overrun)
    );

    // Response DPRAM: registered read, data one cycle after the address
    logic [15:0] mem [0:255];
    always @(posedge clk_in) dpram_rdata <= mem[dpram_raddr];

    int         errors = 0, checks = 0;
    logic [7:0] exp_q[$];
    int         widx_q[$];
    logic [7:0] lit[$];
    int         started_cnt = 0, done_cnt = 0, seen_start = 0, frames_ok = 0, ovr_cnt = 0;
    int         ptr = 0, gap = 0;
    bit         empty_wait = 0, ovr_pend = 0, chk_en = 0, cmp_busy = 0, cmp_v = 0;
    logic [15:0] lfsr = 16'hACE1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] crc_add(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
        return r;
    endfunction

    task automatic put(input logic [7:0] b, input int w);
        exp_q.push_back(b);
        widx_q.push_back(w);
    endtask

    // Expected byte list of one response; widx marks bytes fetched from DPRAM word w
    task automatic build(input logic [7:0] dv, input logic [7:0] fc, input logic [15:0] a,
                         input logic [15:0] d, input logic [7:0] q, input logic [7:0] exc);
        int n;
        logic [15:0] c;
        exp_q.delete();
        widx_q.delete();
        n = (int'(q) > MAXQ) ? MAXQ : int'(q);
        if (exc != 8'h00) begin
            put(dv, -1); put(fc | 8'h80, -1); put(exc, -1);
        end else if (fc == 8'h03 || fc == 8'h04) begin
            put(dv, -1); put(fc, -1); put(8'(2 * n), -1);
            for (int w = 0; w < n; w++) begin
                put(mem[w][15:8], w);
                put(mem[w][7:0], -1);
            end
        end else if (fc == 8'h06) begin
            put(dv, -1); put(fc, -1); put(a[15:8], -1); put(a[7:0], -1);
            put(d[15:8], -1); put(d[7:0], -1);
        end else begin
            return;
        end
        c = 16'hFFFF;
        foreach (exp_q[i]) c = crc_add(c, exp_q[i]);
        put(c[7:0], -1);
        put(c[15:8], -1);
    endtask

    // Per-cycle compare against the byte-list model
    always @(negedge clk_in) begin
        if (chk_en) begin
            if (!rst_n_in) begin
                done_cnt   = started_cnt;
                seen_start = started_cnt;
                ovr_pend   = 1'b0;
            end else begin
                chk("overrun", overrun, ovr_pend);
                if (overrun) ovr_cnt++;
                if (seen_start != started_cnt) begin
                    seen_start = started_cnt;
                    ptr = 0;
                    gap = 0;
                    empty_wait = (exp_q.size() == 0);
                end
                if (done_cnt == started_cnt) begin
                    cmp_busy = 1'b0;
                    chk("idle_valid", tx_byte_valid, 0);
                    chk("idle_busy", busy, 0);
                    chk("idle_frame_done", frame_done, 0);
                end else if (empty_wait) begin
                    cmp_busy = 1'b1;
                    empty_wait = 1'b0;
                    chk("nobyte_busy", busy, 1);
                    chk("nobyte_valid", tx_byte_valid, 0);
                    chk("nobyte_frame_done", frame_done, 0);
                end else if (ptr < exp_q.size()) begin
                    cmp_busy = 1'b1;
                    chk("busy", busy, 1);
                    chk("frame_done_early", frame_done, 0);
                    // Each DPRAM word costs two idle cycles before its high byte
                    cmp_v = !(widx_q[ptr] >= 0 && gap < 2);
                    chk("tx_valid", tx_byte_valid, cmp_v);
                    if (cmp_v) begin
                        chk("tx_byte", tx_byte, exp_q[ptr]);
                        if (tx_byte_valid && tx_byte_ready) begin
                            ptr++;
                            gap = 0;
                        end
                    end else begin
                        chk("dpram_raddr", dpram_raddr, widx_q[ptr]);
                        gap++;
                    end
                end else begin
                    cmp_busy = 1'b0;
                    chk("frame_done", frame_done, 1);
                    chk("busy_at_done", busy, 0);
                    chk("valid_at_done", tx_byte_valid, 0);
                    frames_ok++;
                    done_cnt = started_cnt;
                end
                ovr_pend = handler_done && cmp_busy;
            end
        end
    end

    task automatic step(input bit bp);
        @(posedge clk_in);
        #1;
        if (bp) begin
            lfsr = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            tx_byte_ready = lfsr[0];
        end else begin
            tx_byte_ready = 1'b1;
        end
    endtask

    task automatic launch(input logic [7:0] dv, input logic [7:0] fc, input logic [15:0] a,
                          input logic [15:0] d, input logic [7:0] q, input logic [7:0] exc,
                          input bit bp);
        @(posedge clk_in);
        #1;
        dev_addr = dv; func_code = fc; addr = a; data = d; tx_quantity = q; exception = exc;
        handler_done = 1'b1;
        step(bp);
        handler_done = 1'b0;
        started_cnt++;
        // Scramble request inputs: the frame must come from the latched copy
        dev_addr = 8'hEE; func_code = 8'h55; addr = 16'hDEAD; data = 16'hBEEF;
        tx_quantity = 8'h77; exception = 8'h0B;
    endtask

    task automatic finish_frame(input bit bp, input int limit);
        int n;
        n = 0;
        while (done_cnt != started_cnt && n < limit) begin
            step(bp);
            n++;
        end
        chk("frame_complete", done_cnt == started_cnt, 1);
    endtask

    task automatic pin(input string name, input int len);
        chk({name, "_len"}, exp_q.size(), len);
        foreach (lit[i]) chk(name, exp_q[i], lit[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ok_before;
        rst_n_in = 1'b0; handler_done = 1'b0; dev_addr = 8'h00; func_code = 8'h00;
        addr = 16'h0; data = 16'h0; tx_quantity = 8'h00; exception = 8'h00; tx_byte_ready = 1'b1;
        for (int i = 0; i < 256; i++) mem[i] = {8'(i) ^ 8'hA5, 8'(i * 3 + 1)};
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        chk("rst_valid", tx_byte_valid, 0);
        chk("rst_byte", tx_byte, 0);
        chk("rst_busy", busy, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_raddr", dpram_raddr, 0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        chk_en = 1'b1;
        repeat (2) step(0);

        // Exception response
        build(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd4, 8'h02);
        lit = '{8'h01, 8'h83, 8'h02, 8'hC0, 8'hF1};
        pin("pin_exc", 5);
        launch(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd4, 8'h02, 0);
        finish_frame(0, 100);

        // FC 06 echo
        build(8'h01, 8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00);
        lit = '{8'h01, 8'h06, 8'h00, 8'h01, 8'h00, 8'h03, 8'h98, 8'h0B};
        pin("pin_fc06", 8);
        launch(8'h01, 8'h06, 16'h0001, 16'h0003, 8'd0, 8'h00, 0);
        finish_frame(0, 100);

        // FC 04, four words
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        build(8'h01, 8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
        lit = '{8'h01, 8'h04, 8'h08, 8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
        pin("pin_fc04", 13);
        launch(8'h01, 8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00, 0);
        finish_frame(0, 200);

        // FC 03, one word, pseudo-random backpressure
        build(8'h11, 8'h03, 16'h0000, 16'h0000, 8'd1, 8'h00);
        launch(8'h11, 8'h03, 16'h0000, 16'h0000, 8'd1, 8'h00, 1);
        finish_frame(1, 500);

        // FC 03, zero words
        build(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd0, 8'h00);
        lit = '{8'h01, 8'h03, 8'h00};
        pin("pin_qty0", 5);
        launch(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd0, 8'h00, 0);
        finish_frame(0, 100);

        // Quantity clamp: 200 requested, 125 words sent
        build(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd200, 8'h00);
        lit = '{8'h01, 8'h03, 8'hFA};
        pin("pin_clamp", 255);
        launch(8'h01, 8'h03, 16'h0000, 16'h0000, 8'd200, 8'h00, 0);
        finish_frame(0, 2000);

        // Unsupported FC: no bytes, one frame_done
        build(8'h01, 8'h10, 16'h0000, 16'h0000, 8'd5, 8'h00);
        chk("pin_fc10_len", exp_q.size(), 0);
        launch(8'h01, 8'h10, 16'h0000, 16'h0000, 8'd5, 8'h00, 0);
        finish_frame(0, 50);

        // Overrun: second start mid-frame leaves the frame unaltered
        build(8'h01, 8'h06, 16'h1234, 16'h5678, 8'd0, 8'h00);
        launch(8'h01, 8'h06, 16'h1234, 16'h5678, 8'd0, 8'h00, 0);
        repeat (3) step(0);
        dev_addr = 8'h77; func_code = 8'h03; tx_quantity = 8'd2; exception = 8'h00;
        handler_done = 1'b1;
        step(0);
        handler_done = 1'b0;
        finish_frame(0, 100);
        chk("overrun_count", ovr_cnt, 1);

        // Reset mid-frame aborts without frame_done
        build(8'h01, 8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00);
        launch(8'h01, 8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00, 0);
        repeat (5) step(0);
        ok_before = frames_ok;
        rst_n_in = 1'b0;
        step(0);
        rst_n_in = 1'b1;
        @(negedge clk_in);
        chk("abort_valid", tx_byte_valid, 0);
        chk("abort_byte", tx_byte, 0);
        chk("abort_busy", busy, 0);
        chk("abort_frame_done", frame_done, 0);
        chk("abort_raddr", dpram_raddr, 0);
        repeat (3) step(0);
        chk("abort_no_done", frames_ok, ok_before);

        // Next frame after the abort
        launch(8'h01, 8'h04, 16'h0000, 16'h0000, 8'd4, 8'h00, 0);
        finish_frame(0, 200);
        repeat (3) step(0);
        chk("frames_total", frames_ok, 9);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
